// File: rtl/rob_multi_commit_pkg.sv
// Shared constants and commit classification for the multi-commit reorder buffer.
package rob_multi_commit_pkg;

  localparam int ZERO_TAG = 0;
  localparam int OP_RANGE = 7;

  localparam logic [OP_RANGE-1:0] BRANCH_OP = 7'b1100011;
  localparam logic [OP_RANGE-1:0] JALR_OP   = 7'b1100111;
  localparam logic [OP_RANGE-1:0] STORE_OP  = 7'b0100011;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    KIND_REG,
    KIND_BRANCH,
    KIND_JALR,
    KIND_STORE
  } commit_kind_e;

  function automatic commit_kind_e classify(input logic [OP_RANGE-1:0] op);
    if (op == BRANCH_OP)     return KIND_BRANCH;
    else if (op == JALR_OP)  return KIND_JALR;
    else if (op == STORE_OP) return KIND_STORE;
    else                     return KIND_REG;
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Decides how many entries retire this cycle from the head and head+1 entry fields.
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter int TAG_W    = 5,
  parameter int COMMIT_W = 2
) (
  input  logic [TAG_W-1:0]    count,
  input  logic                head_ready,
  input  logic [OP_RANGE-1:0] head_op,
  input  logic                next_ready,
  input  logic [OP_RANGE-1:0] next_op,
  output logic [1:0]          n_commit,
  output commit_kind_e        kind0,
  output commit_kind_e        kind1
);

  always_comb begin
    kind0    = classify(head_op);
    kind1    = classify(next_op);
    n_commit = 2'd0;
    if (head_ready && count != TAG_W'(ZERO_TAG)) begin
      n_commit = 2'd1;
      // Only plain register writers may pair up; anything else retires alone.
      if (COMMIT_W == 2 && count >= TAG_W'(2) && next_ready &&
          kind0 == KIND_REG && kind1 == KIND_REG)
        n_commit = 2'd2;
    end
  end

endmodule

// File: rtl/rob_multi_commit.sv
// Parametrised reorder buffer: in-order retire of up to COMMIT_W entries, self-flush on mispredict.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 5,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int COMMIT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [TAG_W-1:0]           in_cdb_rob_tag,
  input  logic [DATA_W-1:0]          in_cdb_value,
  input  logic                       in_cdb_isload,
  input  logic                       in_cdb_isjump,
  input  logic [DATA_W-1:0]          in_cdb_jump_addr,
  input  logic [TAG_W-1:0]           in_ls_cdb_rob_tag,
  input  logic [DATA_W-1:0]          in_ls_cdb_value,
  input  logic                       in_assignment_ena,
  input  logic [6:0]                 in_op,
  input  logic [REG_W-1:0]           in_dest,
  input  logic [DATA_W-1:0]          in_pc,
  input  logic                       in_predicted_taken,
  input  logic [TAG_W-1:0]           in_query_tag1,
  input  logic [TAG_W-1:0]           in_query_tag2,
  output logic [DATA_W-1:0]          out_back_value1,
  output logic [DATA_W-1:0]          out_back_value2,
  output logic                       out_back_ready1,
  output logic                       out_back_ready2,
  output logic [TAG_W-1:0]           out_rob_available_tag,
  output logic                       out_rob_ok,
  output logic [COMMIT_W-1:0]        out_reg_valid,
  output logic [COMMIT_W*REG_W-1:0]  out_reg_reg,
  output logic [COMMIT_W*TAG_W-1:0]  out_reg_rob,
  output logic [COMMIT_W*DATA_W-1:0] out_reg_value,
  output logic [TAG_W-1:0]           out_committed_rob_tag,
  output logic                       out_forwarding_ena,
  output logic                       out_forwarding_taken,
  output logic [DATA_W-1:0]          out_forwarding_branch_pc,
  output logic                       out_misbranch,
  output logic [DATA_W-1:0]          out_correct_jump_addr,
  output logic [TAG_W-1:0]           out_count
);

  logic [TAG_W-1:0]    head, tail, count, head1;
  logic                rdy     [0:DEPTH];
  logic [DATA_W-1:0]   val_q   [0:DEPTH];
  logic [DATA_W-1:0]   pc_q    [0:DEPTH];
  logic [DATA_W-1:0]   jaddr_q [0:DEPTH];
  logic [OP_RANGE-1:0] op_q    [0:DEPTH];
  logic [REG_W-1:0]    dest_q  [0:DEPTH];
  logic                pred_q  [0:DEPTH];
  logic                jump_q  [0:DEPTH];

  logic [1:0]       n_sel, n_commit;
  commit_kind_e     kind0, kind1;
  logic             alu_hit, ls_hit, full, alloc, mispredict, flush;
  logic [TAG_W-1:0] slot_tag [0:1];

  function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(DEPTH)) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

  // Operand lookup with same-cycle CDB bypass; result is {ready, value}.
  function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] t);
    if (t == TAG_W'(ZERO_TAG))                return {FALSE, {DATA_W{1'b0}}};
    else if (alu_hit && in_cdb_rob_tag == t)  return {TRUE, in_cdb_value};
    else if (ls_hit && in_ls_cdb_rob_tag == t) return {TRUE, in_ls_cdb_value};
    else                                       return {rdy[t], val_q[t]};
  endfunction

  assign head1   = wrap_inc(head);
  assign alu_hit = (in_cdb_rob_tag != TAG_W'(ZERO_TAG)) && !in_cdb_isload;
  assign ls_hit  = in_ls_cdb_rob_tag != TAG_W'(ZERO_TAG);
  assign full    = count == TAG_W'(DEPTH);

  rob_commit_select #(.TAG_W(TAG_W), .COMMIT_W(COMMIT_W)) u_sel (
    .count      (count),
    .head_ready (rdy[head]),
    .head_op    (op_q[head]),
    .next_ready (rdy[head1]),
    .next_op    (op_q[head1]),
    .n_commit   (n_sel),
    .kind0      (kind0),
    .kind1      (kind1)
  );

  assign n_commit   = ena ? n_sel : 2'd0;
  assign mispredict = (kind0 == KIND_BRANCH && (jump_q[head] ^ pred_q[head])) || kind0 == KIND_JALR;
  assign flush      = (n_commit != 2'd0) && mispredict;
  // A retiring entry frees its slot in the same cycle, so a full buffer can accept one more.
  assign alloc      = ena && in_assignment_ena && (!full || n_commit != 2'd0) && !flush;

  assign slot_tag[0] = head;
  assign slot_tag[1] = head1;

  always_comb begin
    {out_back_ready1, out_back_value1} = lookup(in_query_tag1);
    {out_back_ready2, out_back_value2} = lookup(in_query_tag2);
  end

  assign out_rob_available_tag = full ? TAG_W'(ZERO_TAG) : tail;
  assign out_rob_ok            = count <= TAG_W'(DEPTH - 2);
  assign out_count             = count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= TAG_W'(1);
      tail  <= TAG_W'(1);
      count <= TAG_W'(ZERO_TAG);
    end else if (ena) begin
      if (alloc) tail <= wrap_inc(tail);
      if (n_commit == 2'd2)      head <= wrap_inc(head1);
      else if (n_commit == 2'd1) head <= head1;
      count <= count + TAG_W'(alloc) - TAG_W'(n_commit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i <= DEPTH; i++) rdy[i] <= FALSE;
    end else if (ena) begin
      if (alu_hit) rdy[in_cdb_rob_tag]    <= TRUE;
      if (ls_hit)  rdy[in_ls_cdb_rob_tag] <= TRUE;
      if (alloc)   rdy[tail]              <= FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      if (alu_hit) begin
        val_q[in_cdb_rob_tag]   <= in_cdb_value;
        jump_q[in_cdb_rob_tag]  <= in_cdb_isjump;
        jaddr_q[in_cdb_rob_tag] <= in_cdb_jump_addr;
      end
      if (ls_hit) val_q[in_ls_cdb_rob_tag] <= in_ls_cdb_value;
      if (alloc) begin
        op_q[tail]   <= in_op;
        dest_q[tail] <= in_dest;
        pc_q[tail]   <= in_pc;
        pred_q[tail] <= in_predicted_taken;
      end
    end
  end

  // Commit stage boundary: every retire result is a one-cycle registered pulse.
  always_ff @(posedge clk) begin
    out_reg_valid            <= '0;
    out_reg_reg              <= '0;
    out_reg_rob              <= '0;
    out_reg_value            <= '0;
    out_committed_rob_tag    <= '0;
    out_forwarding_ena       <= FALSE;
    out_forwarding_taken     <= FALSE;
    out_forwarding_branch_pc <= '0;
    out_misbranch            <= FALSE;
    out_correct_jump_addr    <= '0;
    if (!rst && n_commit != 2'd0) begin
      case (kind0)
        KIND_BRANCH: begin
          out_forwarding_ena       <= TRUE;
          out_forwarding_taken     <= jump_q[head];
          out_forwarding_branch_pc <= pc_q[head];
          if (mispredict) begin
            out_misbranch         <= TRUE;
            out_correct_jump_addr <= jump_q[head] ? jaddr_q[head] : pc_q[head] + DATA_W'(4);
          end
        end
        KIND_STORE: out_committed_rob_tag <= head;
        KIND_JALR: begin
          out_forwarding_taken  <= TRUE;
          out_misbranch         <= TRUE;
          out_correct_jump_addr <= jaddr_q[head];
        end
        default: ;
      endcase
      for (int s = 0; s < COMMIT_W; s++) begin
        if ((s == 0 && (kind0 == KIND_REG || kind0 == KIND_JALR)) ||
            (s == 1 && n_commit == 2'd2)) begin
          out_reg_valid[s]                  <= TRUE;
          out_reg_reg[s*REG_W +: REG_W]     <= dest_q[slot_tag[s]];
          out_reg_rob[s*TAG_W +: TAG_W]     <= slot_tag[s];
          out_reg_value[s*DATA_W +: DATA_W] <= val_q[slot_tag[s]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: fill/full, dual commit, bypass, mispredict flush, store, wrap.
module tb_rob_multi_commit;

  localparam logic [6:0] ALU_OP = 7'b0110011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] ST_OP  = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic [4:0]  cdb_tag, ls_tag, q1, q2, dest;
  logic [31:0] cdb_val, cdb_jaddr, ls_val, pc;
  logic        cdb_isload, cdb_isjump, assign_ena, pred;
  logic [6:0]  op;
  logic [31:0] bv1, bv2, fwd_pc, corr;
  logic        br1, br2, ok, fwd_ena, fwd_taken, misb;
  logic [4:0]  avail, committed, count;
  logic [1:0]  rvalid;
  logic [9:0]  rreg, rrob;
  logic [63:0] rval;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  tag;
    logic [4:0]  dest;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t pend[$];

  always #5 clk = ~clk;

  rob_multi_commit dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_cdb_rob_tag(cdb_tag), .in_cdb_value(cdb_val), .in_cdb_isload(cdb_isload),
    .in_cdb_isjump(cdb_isjump), .in_cdb_jump_addr(cdb_jaddr),
    .in_ls_cdb_rob_tag(ls_tag), .in_ls_cdb_value(ls_val),
    .in_assignment_ena(assign_ena), .in_op(op), .in_dest(dest), .in_pc(pc),
    .in_predicted_taken(pred), .in_query_tag1(q1), .in_query_tag2(q2),
    .out_back_value1(bv1), .out_back_value2(bv2), .out_back_ready1(br1), .out_back_ready2(br2),
    .out_rob_available_tag(avail), .out_rob_ok(ok),
    .out_reg_valid(rvalid), .out_reg_reg(rreg), .out_reg_rob(rrob), .out_reg_value(rval),
    .out_committed_rob_tag(committed), .out_forwarding_ena(fwd_ena),
    .out_forwarding_taken(fwd_taken), .out_forwarding_branch_pc(fwd_pc),
    .out_misbranch(misb), .out_correct_jump_addr(corr), .out_count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    cdb_tag = '0; cdb_val = '0; cdb_isload = 1'b0; cdb_isjump = 1'b0; cdb_jaddr = '0;
    ls_tag = '0; ls_val = '0; assign_ena = 1'b0; op = ALU_OP; dest = '0; pc = '0;
    pred = 1'b0; q1 = '0; q2 = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc_one(input logic [6:0] o, input logic [4:0] d, input logic [31:0] p, input logic pr);
    assign_ena = 1'b1; op = o; dest = d; pc = p; pred = pr;
    step();
    clear_in();
  endtask

  // Compares each retiring slot against the in-order expectation queue.
  task automatic step_mon();
    exp_t e;
    step();
    for (int s = 0; s < 2; s++) begin
      if (rvalid[s]) begin
        if (exp_q.size() == 0) begin
          chk("wrap_extra_commit", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wrap_dest", 64'(rreg[s*5 +: 5]), 64'(e.dest));
          chk("wrap_rob", 64'(rrob[s*5 +: 5]), 64'(e.tag));
          chk("wrap_value", 64'(rval[s*32 +: 32]), 64'(e.val));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    ena = 1'b1;
    do_reset();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_avail", 64'(avail), 64'd1);
    chk("reset_ok", 64'(ok), 64'd1);
    chk("reset_valid", 64'(rvalid), 64'd0);
    chk("reset_misb", 64'(misb), 64'd0);

    // Fill to capacity with nothing completing.
    for (int i = 1; i <= 17; i++) begin
      alloc_one(ALU_OP, 5'(i), 32'(i * 4), 1'b0);
      if (i == 14) chk("fill_ok_14", 64'(ok), 64'd1);
      if (i == 15) chk("fill_ok_15", 64'(ok), 64'd0);
      if (i == 15) chk("fill_avail_15", 64'(avail), 64'd16);
      if (i == 16) chk("fill_avail_16", 64'(avail), 64'd0);
    end
    chk("fill_count_17", 64'(count), 64'd16);

    // Dual commit, results arriving out of order.
    do_reset();
    alloc_one(ALU_OP, 5'd5, 32'h10, 1'b0);
    alloc_one(ALU_OP, 5'd6, 32'h14, 1'b0);
    cdb_tag = 5'd2; cdb_val = 32'h22;
    step();
    cdb_tag = 5'd1; cdb_val = 32'h11;
    step();
    clear_in();
    chk("dual_pre_valid", 64'(rvalid), 64'd0);
    step();
    chk("dual_valid", 64'(rvalid), 64'd3);
    chk("dual_reg", 64'(rreg), 64'({5'd6, 5'd5}));
    chk("dual_rob", 64'(rrob), 64'({5'd2, 5'd1}));
    chk("dual_value", rval, {32'h22, 32'h11});
    chk("dual_count", 64'(count), 64'd0);
    step();
    chk("dual_pulse_end", 64'(rvalid), 64'd0);

    // Same-cycle bypass to operand query.
    alloc_one(ALU_OP, 5'd7, 32'h18, 1'b0);
    q1 = 5'd3;
    #1;
    chk("query_not_ready", 64'(br1), 64'd0);
    cdb_tag = 5'd3; cdb_val = 32'hAB;
    #1;
    chk("bypass_ready", 64'(br1), 64'd1);
    chk("bypass_value", 64'(bv1), 64'hAB);
    chk("query_tag0_ready", 64'(br2), 64'd0);
    chk("query_tag0_value", 64'(bv2), 64'd0);
    step();
    cdb_tag = '0; cdb_val = '0;
    #1;
    chk("array_ready", 64'(br1), 64'd1);
    chk("array_value", 64'(bv1), 64'hAB);
    step();
    chk("single_valid", 64'(rvalid), 64'd1);
    chk("single_reg", 64'(rreg[4:0]), 64'd7);
    chk("single_value", 64'(rval[31:0]), 64'hAB);
    clear_in();

    // Branch mispredict with younger entries and an alloc on the flush edge.
    do_reset();
    alloc_one(BR_OP, 5'd0, 32'h400, 1'b0);
    alloc_one(ALU_OP, 5'd8, 32'h404, 1'b0);
    alloc_one(ALU_OP, 5'd9, 32'h408, 1'b0);
    cdb_tag = 5'd1; cdb_isjump = 1'b1; cdb_jaddr = 32'h1000;
    step();
    clear_in();
    assign_ena = 1'b1; op = ALU_OP; dest = 5'd3;
    step();
    clear_in();
    chk("mis_misbranch", 64'(misb), 64'd1);
    chk("mis_addr", 64'(corr), 64'h1000);
    chk("mis_fwd_ena", 64'(fwd_ena), 64'd1);
    chk("mis_fwd_taken", 64'(fwd_taken), 64'd1);
    chk("mis_fwd_pc", 64'(fwd_pc), 64'h400);
    chk("mis_valid", 64'(rvalid), 64'd0);
    chk("mis_count", 64'(count), 64'd0);
    chk("mis_avail", 64'(avail), 64'd1);
    step();
    chk("mis_pulse_end", 64'(misb), 64'd0);

    // Store at head retires alone; ALU op behind it retires next cycle.
    alloc_one(ST_OP, 5'd0, 32'h500, 1'b0);
    alloc_one(ALU_OP, 5'd9, 32'h504, 1'b0);
    cdb_tag = 5'd1; ls_tag = 5'd2; ls_val = 32'h99; q2 = 5'd2;
    #1;
    chk("ls_bypass_ready", 64'(br2), 64'd1);
    chk("ls_bypass_value", 64'(bv2), 64'h99);
    step();
    clear_in();
    step();
    chk("store_tag", 64'(committed), 64'd1);
    chk("store_valid", 64'(rvalid), 64'd0);
    step();
    chk("after_store_valid", 64'(rvalid), 64'd1);
    chk("after_store_reg", 64'(rreg[4:0]), 64'd9);
    chk("after_store_value", 64'(rval[31:0]), 64'h99);
    chk("after_store_rob", 64'(rrob[4:0]), 64'd2);
    chk("after_store_tag", 64'(committed), 64'd0);

    // Wrap: 12 entries, drain, then 8 more crossing tag 16 -> 1.
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < (phase == 0 ? 12 : 8); i++) begin
        int idx;
        idx = phase * 12 + i;
        if (phase == 1) chk("wrap_avail", 64'(avail), 64'(((12 + i) % 16) + 1));
        e.tag = avail; e.dest = 5'((idx % 31) + 1); e.val = 32'h1000 + 32'(idx);
        exp_q.push_back(e);
        pend.push_back(e);
        assign_ena = 1'b1; op = ALU_OP; dest = e.dest; pc = 32'(idx * 4);
        step_mon();
        clear_in();
      end
      while (pend.size() > 0) begin
        e = pend.pop_front();
        cdb_tag = e.tag; cdb_val = e.val;
        step_mon();
        clear_in();
      end
      step_mon();
      step_mon();
      chk("wrap_drained_count", 64'(count), 64'd0);
    end
    chk("wrap_all_committed", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
